wb_decoder: RTL and testbench
=============================

Name: wb_decoder

Overview:
- Single-master to four-slave Wishbone address decoder. It is the slave-side counterpart of the bus arbiter.
- Takes the arbitrated owner bus and routes each cycle to one of four slaves using base/mask address matching.
- The slave selection is latched for the whole cycle (CYC high).
- Unmapped accesses and hung slaves are terminated with a decoder-generated ack, so the CPU never stalls.

Parameters:
- S1_BASE, 32'h0000_0000, slave 1 match value
- S1_MASK, 32'hF000_0000, slave 1 compare mask (slave 1 hits when (adr & S1_MASK) == S1_BASE)
- S2_BASE / S2_MASK, 32'h1000_0000 / 32'hF000_0000, slave 2
- S3_BASE / S3_MASK, 32'h2000_0000 / 32'hF000_0000, slave 3
- S4_BASE / S4_MASK, 32'h3000_0000 / 32'hF000_0000, slave 4
- TIMEOUT, 255, consecutive un-acked strobe cycles before abort (range 1..2^CNT_W-1)
- CNT_W, 8, timeout counter width

Ports:
- wb_clk_i  in  1  bus clock
- wb_rst_i  in  1  asynchronous active-high reset
- wbm_adr_i, wbm_dat_i  in  32 each  master address / write data
- wbm_cyc_i, wbm_stb_i, wbm_we_i  in  1 each  master controls
- wbm_cti_i  in  3, wbm_bte_i  in  2, wbm_sel_i  in  4  master burst info / byte selects
- wbm_dat_o  out  32  read data to master
- wbm_ack_o  out  1  ack to master
- wbsN_adr_o, wbsN_dat_o  out  32 each (N=1..4)  broadcast copies of wbm_adr_i / wbm_dat_i
- wbsN_we_o, wbsN_cti_o, wbsN_bte_o, wbsN_sel_o  out  1/3/2/4  broadcast copies of master controls
- wbsN_cyc_o, wbsN_stb_o  out  1 each  gated; asserted only on the selected slave
- wbsN_dat_i  in  32  slave read data
- wbsN_ack_i  in  1  slave ack
- wbslave_o  out  3  current selection: 0..3 = slave 1..4, 4 = none
- timeout_o  out  1  one-cycle pulse on abort
- unmapped_o  out  1  one-cycle pulse on each decoder ack to an unmapped address

Behaviour:
- Decode: combinational on wbm_adr_i. Lowest-numbered matching slave wins on overlap; no match gives NONE (4).
- State machine: IDLE, ACTIVE, ABORT.
  - IDLE: routing uses the live decode, so there is zero added latency on the first cycle. On an edge with wbm_cyc_i=1, sel_q <= decode and state goes to ACTIVE.
  - ACTIVE: routing uses sel_q only; address changes inside a burst do not reselect. wbm_cyc_i=0 returns to IDLE.
  - ACTIVE to ABORT on timeout. ABORT returns to IDLE when wbm_cyc_i=0.
- Slave gating:
  - wbsN_cyc_o = wbm_cyc_i & (sel==N) & state!=ABORT & !wb_rst_i.
  - wbsN_stb_o: same gating, applied to wbm_stb_i.
- Normal ack path: wbm_ack_o = wbsN_ack_i of the selected slave, combinational. Unselected slave acks are ignored. wbm_dat_o = selected slave's dat_i.
- Error ack (err_ack_q): set on an edge when cyc&stb&(sel==NONE or ABORT)&!err_ack_q, otherwise cleared.
  - Result: one ack per strobe, asserted in the cycle after stb.
  - While err_ack_q=1, wbm_ack_o=1 and wbm_dat_o=32'hFFFF_FFFF.
  - unmapped_o pulses with each err_ack_q when sel==NONE.
- Timeout counter:
  - Increments each cycle with cyc&stb, selected slave valid, and that slave's ack low. It is independent of IDLE/ACTIVE.
  - Cleared on slave ack, on stb low, or on cyc low.
  - When count==TIMEOUT-1 and no ack in that cycle: the next edge forces ABORT, sets err_ack_q (ack with 32'hFFFF_FFFF) and pulses timeout_o.
  - Slave cyc/stb drop in the same cycle as the ABORT entry.
- Simultaneous events:
  - A slave ack in the terminal count cycle wins: no timeout, normal ack.
  - cyc dropping while err_ack_q=1: err_ack_q clears next edge and state returns to IDLE.
- Reset (asynchronous, including mid-cycle):
  - State goes to IDLE, sel_q to NONE, counter to 0, err_ack_q to 0.
  - timeout_o and unmapped_o go to 0.
  - All wbsN_cyc_o and wbsN_stb_o go to 0 immediately.
  - wbslave_o shows the live decode once reset is released.

Test Plan:
- Single read to 32'h1000_0040, slave 2 acks one cycle after stb with 32'h1234_5678 -> only wbs2 cyc/stb high, wbm_dat_o=32'h1234_5678 with ack, wbslave_o=1.
- Burst starting at 32'h2FFF_FFF8 that increments into 32'h3000_0000 while cyc is held -> slave 3 stays selected for all beats, slave 4 never strobed.
- Write to 32'h8000_0000 (unmapped) -> no slave strobed, ack one cycle after stb, dat=32'hFFFF_FFFF, unmapped_o one pulse.
- TIMEOUT=16, slave 1 never acks, stb held from cycle 0 -> wbm_ack_o and timeout_o in cycle 16, wbs1_cyc_o low from cycle 16, further strobes error-acked until cyc drops, then IDLE.
- TIMEOUT=16, slave acks exactly in cycle 15 -> normal ack, timeout_o stays 0, counter cleared.
- wb_rst_i asserted mid-burst to slave 4 -> wbs4_cyc_o/stb_o fall without waiting for a clock edge. After release with cyc low: state IDLE, wbslave_o follows the address.

Source files
------------

// File: rtl/wb_decoder.sv
//------------------------------------------------------------------------------
// Module      : wb_decoder
// Description : Single-master to four-slave Wishbone address decoder.
//               Routes the arbitrated master bus to one of four slaves by
//               base/mask matching. The selection is held for the whole
//               cycle (CYC high). Unmapped accesses and hung slaves are
//               terminated by a decoder-generated ack (data 32'hFFFF_FFFF).
// Ports       : wb_clk_i / wb_rst_i      clock, async active-high reset
//               wbm_*_i / wbm_*_o        master-side bus
//               wbsN_*_o / wbsN_*_i      slave-side buses, N = 1..4
//               wbslave_o                current selection (0..3, 4 = none)
//               timeout_o                one-cycle pulse on abort
//               unmapped_o               one-cycle pulse per unmapped ack
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wb_decoder #(
    parameter logic [31:0] S1_BASE = 32'h0000_0000,
    parameter logic [31:0] S1_MASK = 32'hF000_0000,
    parameter logic [31:0] S2_BASE = 32'h1000_0000,
    parameter logic [31:0] S2_MASK = 32'hF000_0000,
    parameter logic [31:0] S3_BASE = 32'h2000_0000,
    parameter logic [31:0] S3_MASK = 32'hF000_0000,
    parameter logic [31:0] S4_BASE = 32'h3000_0000,
    parameter logic [31:0] S4_MASK = 32'hF000_0000,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    // master side
    input  logic [31:0] wbm_adr_i,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_cyc_i,
    input  logic        wbm_stb_i,
    input  logic        wbm_we_i,
    input  logic [2:0]  wbm_cti_i,
    input  logic [1:0]  wbm_bte_i,
    input  logic [3:0]  wbm_sel_i,
    output logic [31:0] wbm_dat_o,
    output logic        wbm_ack_o,
    // slave 1
    output logic [31:0] wbs1_adr_o,
    output logic [31:0] wbs1_dat_o,
    output logic        wbs1_we_o,
    output logic [2:0]  wbs1_cti_o,
    output logic [1:0]  wbs1_bte_o,
    output logic [3:0]  wbs1_sel_o,
    output logic        wbs1_cyc_o,
    output logic        wbs1_stb_o,
    input  logic [31:0] wbs1_dat_i,
    input  logic        wbs1_ack_i,
    // slave 2
    output logic [31:0] wbs2_adr_o,
    output logic [31:0] wbs2_dat_o,
    output logic        wbs2_we_o,
    output logic [2:0]  wbs2_cti_o,
    output logic [1:0]  wbs2_bte_o,
    output logic [3:0]  wbs2_sel_o,
    output logic        wbs2_cyc_o,
    output logic        wbs2_stb_o,
    input  logic [31:0] wbs2_dat_i,
    input  logic        wbs2_ack_i,
    // slave 3
    output logic [31:0] wbs3_adr_o,
    output logic [31:0] wbs3_dat_o,
    output logic        wbs3_we_o,
    output logic [2:0]  wbs3_cti_o,
    output logic [1:0]  wbs3_bte_o,
    output logic [3:0]  wbs3_sel_o,
    output logic        wbs3_cyc_o,
    output logic        wbs3_stb_o,
    input  logic [31:0] wbs3_dat_i,
    input  logic        wbs3_ack_i,
    // slave 4
    output logic [31:0] wbs4_adr_o,
    output logic [31:0] wbs4_dat_o,
    output logic        wbs4_we_o,
    output logic [2:0]  wbs4_cti_o,
    output logic [1:0]  wbs4_bte_o,
    output logic [3:0]  wbs4_sel_o,
    output logic        wbs4_cyc_o,
    output logic        wbs4_stb_o,
    input  logic [31:0] wbs4_dat_i,
    input  logic        wbs4_ack_i,
    // status
    output logic [2:0]  wbslave_o,
    output logic        timeout_o,
    output logic        unmapped_o
);

    localparam logic [2:0]       c_SEL_NONE = 3'd4;
    localparam logic [CNT_W-1:0] c_TERM     = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);
    localparam logic [31:0]      c_ERR_DAT  = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_ABORT  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_sel_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err_ack;
    logic             r_timeout;
    logic             r_unmapped;

    logic [31:0] w_base [4];
    logic [31:0] w_mask [4];
    logic [31:0] w_sdat [4];
    logic [3:0]  w_sack;
    logic [2:0]  w_dec;
    logic [2:0]  w_sel;
    logic        w_sel_valid;
    logic        w_route;
    logic [3:0]  w_cyc_vec;
    logic [3:0]  w_stb_vec;
    logic        w_sack_sel;
    logic        w_slv_ack;
    logic        w_cnt_inc;
    logic        w_timeout;
    logic        w_err_set;

    assign w_base[0] = S1_BASE;
    assign w_base[1] = S2_BASE;
    assign w_base[2] = S3_BASE;
    assign w_base[3] = S4_BASE;
    assign w_mask[0] = S1_MASK;
    assign w_mask[1] = S2_MASK;
    assign w_mask[2] = S3_MASK;
    assign w_mask[3] = S4_MASK;

    assign w_sdat[0] = wbs1_dat_i;
    assign w_sdat[1] = wbs2_dat_i;
    assign w_sdat[2] = wbs3_dat_i;
    assign w_sdat[3] = wbs4_dat_i;
    assign w_sack    = {wbs4_ack_i, wbs3_ack_i, wbs2_ack_i, wbs1_ack_i};

    // Scan from the highest slave down so the lowest-numbered match wins.
    always_comb begin
        w_dec = c_SEL_NONE;
        for (int i = 3; i >= 0; i--) begin
            if ((wbm_adr_i & w_mask[i]) == w_base[i]) begin
                w_dec = 3'(i);
            end
        end
    end

    // Live decode in IDLE gives zero-latency routing on the first beat;
    // afterwards the latched selection holds through address changes.
    assign w_sel       = (r_state == ST_IDLE) ? w_dec : r_sel_q;
    assign w_sel_valid = ~w_sel[2];
    assign w_route     = wbm_cyc_i & (r_state != ST_ABORT) & ~wb_rst_i;

    always_comb begin
        w_cyc_vec = 4'b0000;
        if (w_route && w_sel_valid) begin
            w_cyc_vec[w_sel[1:0]] = 1'b1;
        end
    end
    assign w_stb_vec = w_cyc_vec & {4{wbm_stb_i}};

    assign w_sack_sel = w_sel_valid & w_sack[w_sel[1:0]];
    assign w_slv_ack  = w_route & w_sack_sel;

    assign wbm_ack_o = r_err_ack | w_slv_ack;
    assign wbm_dat_o = r_err_ack   ? c_ERR_DAT :
                       w_sel_valid ? w_sdat[w_sel[1:0]] : 32'h0000_0000;

    // Count strobed cycles the selected slave leaves un-acked; an ack in the
    // terminal cycle suppresses the abort because it masks w_cnt_inc.
    assign w_cnt_inc = wbm_cyc_i & wbm_stb_i & w_sel_valid &
                       (r_state != ST_ABORT) & ~w_sack_sel;
    assign w_timeout = w_cnt_inc & (r_cnt == c_TERM);

    // The !r_err_ack term makes a held strobe receive one ack per two cycles,
    // i.e. exactly one ack per Wishbone classic strobe.
    assign w_err_set = wbm_cyc_i & wbm_stb_i & ~r_err_ack &
                       (~w_sel_valid | (r_state == ST_ABORT));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (wbm_cyc_i) begin
                    w_state_nxt = w_timeout ? ST_ABORT : ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (!wbm_cyc_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_timeout) begin
                    w_state_nxt = ST_ABORT;
                end
            end
            ST_ABORT: begin
                if (!wbm_cyc_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state    <= ST_IDLE;
            r_sel_q    <= c_SEL_NONE;
            r_cnt      <= '0;
            r_err_ack  <= 1'b0;
            r_timeout  <= 1'b0;
            r_unmapped <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && wbm_cyc_i) begin
                r_sel_q <= w_dec;
            end
            r_cnt      <= (w_cnt_inc && !w_timeout) ? (r_cnt + c_ONE) : '0;
            r_err_ack  <= w_err_set | w_timeout;
            r_timeout  <= w_timeout;
            r_unmapped <= w_err_set & ~w_sel_valid;
        end
    end

    assign wbslave_o  = w_sel;
    assign timeout_o  = r_timeout;
    assign unmapped_o = r_unmapped;

    // Broadcast copies of the master request.
    assign wbs1_adr_o = wbm_adr_i;
    assign wbs2_adr_o = wbm_adr_i;
    assign wbs3_adr_o = wbm_adr_i;
    assign wbs4_adr_o = wbm_adr_i;
    assign wbs1_dat_o = wbm_dat_i;
    assign wbs2_dat_o = wbm_dat_i;
    assign wbs3_dat_o = wbm_dat_i;
    assign wbs4_dat_o = wbm_dat_i;
    assign wbs1_we_o  = wbm_we_i;
    assign wbs2_we_o  = wbm_we_i;
    assign wbs3_we_o  = wbm_we_i;
    assign wbs4_we_o  = wbm_we_i;
    assign wbs1_cti_o = wbm_cti_i;
    assign wbs2_cti_o = wbm_cti_i;
    assign wbs3_cti_o = wbm_cti_i;
    assign wbs4_cti_o = wbm_cti_i;
    assign wbs1_bte_o = wbm_bte_i;
    assign wbs2_bte_o = wbm_bte_i;
    assign wbs3_bte_o = wbm_bte_i;
    assign wbs4_bte_o = wbm_bte_i;
    assign wbs1_sel_o = wbm_sel_i;
    assign wbs2_sel_o = wbm_sel_i;
    assign wbs3_sel_o = wbm_sel_i;
    assign wbs4_sel_o = wbm_sel_i;

    // Gated per-slave cycle/strobe.
    assign wbs1_cyc_o = w_cyc_vec[0];
    assign wbs2_cyc_o = w_cyc_vec[1];
    assign wbs3_cyc_o = w_cyc_vec[2];
    assign wbs4_cyc_o = w_cyc_vec[3];
    assign wbs1_stb_o = w_stb_vec[0];
    assign wbs2_stb_o = w_stb_vec[1];
    assign wbs3_stb_o = w_stb_vec[2];
    assign wbs4_stb_o = w_stb_vec[3];

endmodule

`default_nettype wire

// File: tb/tb_wb_decoder.sv
//------------------------------------------------------------------------------
// Module      : tb_wb_decoder
// Description : Self-checking bench for wb_decoder (TIMEOUT = 16). A small
//               transaction-level model predicts selection, ack cycle, data
//               and status pulses from the address map and slave ack delay.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_wb_decoder;

    localparam int TMO = 16;

    logic        clk;
    logic        rst;
    logic [31:0] m_adr;
    logic [31:0] m_dat;
    logic        m_cyc;
    logic        m_stb;
    logic        m_we;
    logic [2:0]  m_cti;
    logic [1:0]  m_bte;
    logic [3:0]  m_sel;
    wire  [31:0] m_dat_o;
    wire         m_ack_o;
    wire  [31:0] o_adr [4];
    wire  [31:0] o_dat [4];
    wire  [2:0]  o_cti [4];
    wire  [1:0]  o_bte [4];
    wire  [3:0]  o_sel [4];
    wire  [3:0]  o_we;
    wire  [3:0]  o_cyc;
    wire  [3:0]  o_stb;
    logic [31:0] s_dat [4];
    logic [3:0]  s_ack;
    wire  [2:0]  slv;
    wire         tmo;
    wire         unm;

    int n_cmp;
    int n_mis;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wb_decoder #(.TIMEOUT(TMO), .CNT_W(8)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb),
        .wbm_we_i(m_we), .wbm_cti_i(m_cti), .wbm_bte_i(m_bte), .wbm_sel_i(m_sel),
        .wbm_dat_o(m_dat_o), .wbm_ack_o(m_ack_o),
        .wbs1_adr_o(o_adr[0]), .wbs1_dat_o(o_dat[0]), .wbs1_we_o(o_we[0]), .wbs1_cti_o(o_cti[0]),
        .wbs1_bte_o(o_bte[0]), .wbs1_sel_o(o_sel[0]), .wbs1_cyc_o(o_cyc[0]), .wbs1_stb_o(o_stb[0]),
        .wbs1_dat_i(s_dat[0]), .wbs1_ack_i(s_ack[0]),
        .wbs2_adr_o(o_adr[1]), .wbs2_dat_o(o_dat[1]), .wbs2_we_o(o_we[1]), .wbs2_cti_o(o_cti[1]),
        .wbs2_bte_o(o_bte[1]), .wbs2_sel_o(o_sel[1]), .wbs2_cyc_o(o_cyc[1]), .wbs2_stb_o(o_stb[1]),
        .wbs2_dat_i(s_dat[1]), .wbs2_ack_i(s_ack[1]),
        .wbs3_adr_o(o_adr[2]), .wbs3_dat_o(o_dat[2]), .wbs3_we_o(o_we[2]), .wbs3_cti_o(o_cti[2]),
        .wbs3_bte_o(o_bte[2]), .wbs3_sel_o(o_sel[2]), .wbs3_cyc_o(o_cyc[2]), .wbs3_stb_o(o_stb[2]),
        .wbs3_dat_i(s_dat[2]), .wbs3_ack_i(s_ack[2]),
        .wbs4_adr_o(o_adr[3]), .wbs4_dat_o(o_dat[3]), .wbs4_we_o(o_we[3]), .wbs4_cti_o(o_cti[3]),
        .wbs4_bte_o(o_bte[3]), .wbs4_sel_o(o_sel[3]), .wbs4_cyc_o(o_cyc[3]), .wbs4_stb_o(o_stb[3]),
        .wbs4_dat_i(s_dat[3]), .wbs4_ack_i(s_ack[3]),
        .wbslave_o(slv), .timeout_o(tmo), .unmapped_o(unm)
    );

    // Reference address map: index of the first matching slave, 4 if none.
    function automatic int ref_decode(input logic [31:0] a);
        logic [31:0] base [4];
        logic [31:0] mask [4];
        base = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h3000_0000};
        mask = '{32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000};
        for (int i = 0; i < 4; i++) begin
            if ((a & mask[i]) == base[i]) return i;
        end
        return 4;
    endfunction

    // Cycle (counted from the first strobe cycle) in which the master sees ack.
    function automatic int exp_ack_cycle(input int sel, input int delay);
        if (sel == 4) return 1;
        if (delay >= 0 && delay < TMO) return delay;
        return TMO;
    endfunction

    task automatic idle_bus();
        m_cyc = 1'b0;
        m_stb = 1'b0;
        s_ack = 4'b0000;
    endtask

    // One strobe held until ack (plus 'extra' further strobe cycles); the
    // slave chosen by the model acks in cycle 'delay' (-1 = never), the other
    // slaves drive random acks that must be ignored.
    task automatic run_txn(input string name, input logic [31:0] adr, input int delay,
                           input int extra, input logic [31:0] rdat);
        int          sel;
        int          ackc;
        int          last;
        bit          err;
        bit          bc_ok;
        logic [31:0] sdat [4];
        logic [3:0]  exp_vec;
        logic        exp_ack;
        logic        exp_un;
        logic        exp_to;
        logic [31:0] exp_dat;
        sel  = ref_decode(adr);
        ackc = exp_ack_cycle(sel, delay);
        err  = (sel == 4) || !(delay >= 0 && delay < TMO);
        last = ackc + extra;
        for (int i = 0; i < 4; i++) sdat[i] = $urandom;
        if (sel < 4 && rdat != 32'h0) sdat[sel] = rdat;
        @(posedge clk); #1;
        m_adr = adr; m_dat = $urandom; m_we = 1'($urandom); m_sel = 4'($urandom);
        m_cti = 3'($urandom); m_bte = 2'($urandom); m_cyc = 1'b1; m_stb = 1'b1;
        for (int c = 0; c <= last; c++) begin
            for (int i = 0; i < 4; i++) begin
                s_dat[i] = sdat[i];
                s_ack[i] = (i == sel) ? (c == delay) : 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            exp_vec = (sel < 4 && (!err || c < TMO)) ? 4'(1 << sel) : 4'b0000;
            if (c < ackc)       exp_ack = 1'b0;
            else if (c == ackc) exp_ack = 1'b1;
            else                exp_ack = (((c - ackc) % 2) == 0);
            exp_un  = exp_ack && (sel == 4);
            exp_to  = (c == ackc) && err && (sel < 4);
            exp_dat = err ? 32'hFFFF_FFFF : ((sel < 4) ? sdat[sel] : 32'h0);
            n_cmp++;
            if (o_cyc !== exp_vec || o_stb !== exp_vec) begin
                n_mis++;
                $display("FAIL %s gating c=%0d: cyc=%b stb=%b, expected %b", name, c, o_cyc, o_stb, exp_vec);
            end
            n_cmp++;
            if (m_ack_o !== exp_ack || slv !== 3'(sel)) begin
                n_mis++;
                $display("FAIL %s ack/sel c=%0d: ack=%b slave=%0d, expected ack=%b slave=%0d",
                         name, c, m_ack_o, slv, exp_ack, sel);
            end
            n_cmp++;
            if (tmo !== exp_to || unm !== exp_un) begin
                n_mis++;
                $display("FAIL %s pulses c=%0d: timeout=%b unmapped=%b, expected %b %b",
                         name, c, tmo, unm, exp_to, exp_un);
            end
            if (exp_ack) begin
                n_cmp++;
                if (m_dat_o !== exp_dat) begin
                    n_mis++;
                    $display("FAIL %s data c=%0d: got %h expected %h", name, c, m_dat_o, exp_dat);
                end
            end
            if (c == 0) begin
                bc_ok = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    if (o_adr[i] !== m_adr || o_dat[i] !== m_dat || o_we[i] !== m_we ||
                        o_cti[i] !== m_cti || o_bte[i] !== m_bte || o_sel[i] !== m_sel) bc_ok = 1'b0;
                end
                n_cmp++;
                if (!bc_ok) begin
                    n_mis++;
                    $display("FAIL %s broadcast: slave copies differ from master adr=%h dat=%h", name, m_adr, m_dat);
                end
            end
            if (c < last) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        idle_bus();
        @(negedge clk);
        n_cmp++;
        if (m_ack_o !== 1'b0 || o_cyc !== 4'b0000) begin
            n_mis++;
            $display("FAIL %s release: ack=%b cyc=%b, expected 0 0000", name, m_ack_o, o_cyc);
        end
        // One edge later the decoder must be back in IDLE, following the live address.
        @(posedge clk); #1;
        m_adr = $urandom;
        @(negedge clk);
        n_cmp++;
        if (slv !== 3'(ref_decode(m_adr))) begin
            n_mis++;
            $display("FAIL %s idle_decode: adr=%h slave=%0d expected %0d", name, m_adr, slv, ref_decode(m_adr));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m_adr = 32'h1000_0000; m_cyc = 1'b1; m_stb = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (o_cyc !== 4'b0000 || o_stb !== 4'b0000 || m_ack_o !== 1'b0 || tmo !== 1'b0 || unm !== 1'b0) begin
            n_mis++;
            $display("FAIL reset_state: cyc=%b stb=%b ack=%b timeout=%b unmapped=%b, expected all 0",
                     o_cyc, o_stb, m_ack_o, tmo, unm);
        end
        idle_bus();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (slv !== 3'd1) begin
            n_mis++;
            $display("FAIL reset_release_decode: slave=%0d expected 1", slv);
        end
    endtask

    task automatic test_single_read();
        run_txn("single_read", 32'h1000_0040, 1, 0, 32'h1234_5678);
    endtask

    task automatic test_burst_cross();
        logic [31:0] a;
        a = 32'h2FFF_FFF8;
        @(posedge clk); #1;
        m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0;
        for (int b = 0; b < 4; b++) begin
            m_adr = a + 32'(b * 4);
            s_ack = 4'b1111;
            for (int i = 0; i < 4; i++) s_dat[i] = $urandom;
            @(negedge clk);
            n_cmp++;
            if (slv !== 3'd2 || o_cyc !== 4'b0100 || o_stb !== 4'b0100 ||
                m_ack_o !== 1'b1 || m_dat_o !== s_dat[2]) begin
                n_mis++;
                $display("FAIL burst beat %0d adr=%h: slave=%0d cyc=%b stb=%b ack=%b dat=%h, expected 2 0100 0100 1 %h",
                         b, m_adr, slv, o_cyc, o_stb, m_ack_o, m_dat_o, s_dat[2]);
            end
            @(posedge clk); #1;
        end
        idle_bus();
        @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic test_unmapped();
        run_txn("unmapped", 32'h8000_0000, -1, 0, 32'h0);
    endtask

    task automatic test_timeout();
        run_txn("timeout", 32'h0000_0100, -1, 2, 32'h0);
    endtask

    task automatic test_ack_at_terminal();
        run_txn("terminal_ack_a", 32'h0000_1000, TMO - 1, 0, 32'h0);
        run_txn("terminal_ack_b", 32'h2000_0010, TMO - 1, 0, 32'h0);
    endtask

    task automatic test_reset_mid_burst();
        @(posedge clk); #1;
        m_adr = 32'h3000_0000; m_cyc = 1'b1; m_stb = 1'b1; s_ack = 4'b0000;
        @(negedge clk);
        n_cmp++;
        if (o_cyc !== 4'b1000 || o_stb !== 4'b1000) begin
            n_mis++;
            $display("FAIL rst_burst_start: cyc=%b stb=%b expected 1000", o_cyc, o_stb);
        end
        @(posedge clk); #1;
        m_adr = 32'h3000_0004;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (o_cyc !== 4'b0000 || o_stb !== 4'b0000) begin
            n_mis++;
            $display("FAIL rst_async_gate: cyc=%b stb=%b expected 0000 before any edge", o_cyc, o_stb);
        end
        @(posedge clk); #1;
        idle_bus();
        @(posedge clk); #1;
        rst = 1'b0;
        m_adr = 32'h1000_0000;
        @(negedge clk);
        n_cmp++;
        if (slv !== 3'd1 || m_ack_o !== 1'b0 || tmo !== 1'b0 || unm !== 1'b0 || o_cyc !== 4'b0000) begin
            n_mis++;
            $display("FAIL rst_release: slave=%0d ack=%b timeout=%b unmapped=%b cyc=%b, expected 1 0 0 0 0000",
                     slv, m_ack_o, tmo, unm, o_cyc);
        end
        #1 m_adr = 32'h8000_0000;
        #1;
        n_cmp++;
        if (slv !== 3'd4) begin
            n_mis++;
            $display("FAIL rst_release_unmapped: slave=%0d expected 4", slv);
        end
        run_txn("after_reset", 32'h3000_0020, 2, 0, 32'h0);
    endtask

    task automatic test_random();
        logic [31:0] a;
        int          d;
        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(0, 4) == 0) a = $urandom;
            else                          a = {4'($urandom_range(0, 9)), 28'($urandom)};
            d = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TMO + 1));
            run_txn("random", a, d, 0, 32'h0);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        rst   = 1'b1;
        m_adr = '0; m_dat = '0; m_we = 1'b0; m_cti = '0; m_bte = '0; m_sel = '0;
        idle_bus();
        for (int i = 0; i < 4; i++) s_dat[i] = '0;
        test_reset();
        test_single_read();
        test_burst_cross();
        test_unmapped();
        test_timeout();
        test_ack_at_terminal();
        test_reset_mid_burst();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
